mac_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one mac_with_adders_16bit core among NUM_REQ requesters.
- Per job it:
  - grants one pending requester;
  - captures that requester's operands;
  - clears the MAC, pulses start and waits for done;
  - returns the product/accumulation to the granted requester with a one-cycle response strobe.
- Sits between DSP front-end channels (filter taps, correlators) and the single shared MAC instance.

---
 rtl/mac_rr_scheduler.sv | 139 +++++++++++++
 tb/tb_mac_rr_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler sharing one MAC core among NUM_REQ requesters.
// Optional watchdog on the MAC done flag: define MAC_TIMEOUT_EN.
module mac_rr_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [2*DATA_WIDTH-1:0]       rsp_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          mac_clr,
    output logic                          mac_start,
    output logic [DATA_WIDTH-1:0]         mac_a,
    output logic [DATA_WIDTH-1:0]         mac_b,
    input  logic                          mac_done,
    input  logic [2*DATA_WIDTH-1:0]       mac_acc,
    output logic                          err
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_START, S_WAIT, S_RESP} state_t;

    state_t                    r_state;
    logic [IW-1:0]             r_last;
    logic [IW-1:0]             r_grant;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [2*DATA_WIDTH-1:0]   r_rsp_data;
    logic                      r_mac_clr;
    logic                      r_mac_start;
    logic [DATA_WIDTH-1:0]     r_mac_a;
    logic [DATA_WIDTH-1:0]     r_mac_b;
    logic                      w_found;
    logic [IW-1:0]             w_pick;
    logic [IW-1:0]             w_idx;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mac_rr_scheduler: unsupported parameter set");
    end

    // Search starts just after the last served channel, so it has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = IW'((int'(r_last) + off) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

`ifdef MAC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last      <= IW'(NUM_REQ - 1);
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_mac_clr   <= 1'b0;
            r_mac_start <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
`ifdef MAC_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: if (w_found) begin
                    r_grant   <= w_pick;
                    r_mac_a   <= req_a[w_pick*DATA_WIDTH +: DATA_WIDTH];
                    r_mac_b   <= req_b[w_pick*DATA_WIDTH +: DATA_WIDTH];
                    r_mac_clr <= 1'b1;
                    r_state   <= S_CLR;
                end
                S_CLR: begin
                    r_mac_clr   <= 1'b0;
                    r_mac_start <= 1'b1;
                    r_state     <= S_START;
                end
                S_START: begin
                    r_mac_start <= 1'b0;
                    r_state     <= S_WAIT;
`ifdef MAC_TIMEOUT_EN
                    r_cnt       <= '0;
`endif
                end
                S_WAIT: if (mac_done) begin
                    r_rsp_data           <= mac_acc;
                    r_rsp_valid[r_grant] <= 1'b1;
                    r_state              <= S_RESP;
                end
`ifdef MAC_TIMEOUT_EN
                else if (r_cnt == CW'(TIMEOUT_CYC)) begin
                    r_rsp_data           <= '0;
                    r_rsp_valid[r_grant] <= 1'b1;
                    r_err                <= 1'b1;
                    r_state              <= S_RESP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
`endif
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_last      <= r_grant;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;
    assign mac_clr   = r_mac_clr;
    assign mac_start = r_mac_start;
    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Scoreboard bench for mac_rr_scheduler: a round-robin job model predicts the
// response order, a negedge monitor pops and compares every response strobe.
module tb_mac_rr_scheduler;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_a, req_b;
    logic [N-1:0]      rsp_valid;
    logic [2*DW-1:0]   rsp_data;
    logic              busy;
    logic [1:0]        grant_id;
    logic              mac_clr, mac_start, mac_done, err;
    logic [DW-1:0]     mac_a, mac_b;
    logic [2*DW-1:0]   mac_acc;

    always #5 clk = ~clk;

    mac_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .grant_id(grant_id),
        .mac_clr(mac_clr), .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
        .mac_done(mac_done), .mac_acc(mac_acc), .err(err)
    );

    // MAC core model: clear, then acc += a*b, done m_lat cycles after start.
    int          m_lat  = 4;
    bit          m_hang = 1'b0;
    logic [31:0] m_accr = '0, m_prod = '0;
    logic        m_done = 1'b0, m_run = 1'b0;
    int          m_cnt  = 0;
    assign mac_done = m_done;
    assign mac_acc  = m_accr;

    always @(posedge clk) begin
        if (mac_clr) begin
            m_accr <= '0; m_done <= 1'b0; m_run <= 1'b0;
        end else if (mac_start) begin
            m_prod <= 32'(mac_a) * 32'(mac_b);
            m_run  <= !m_hang;
            m_cnt  <= m_lat;
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1; m_accr <= m_accr + m_prod; m_run <= 1'b0;
            end else m_cnt <= m_cnt - 1;
        end
    end

    typedef struct { int ch; logic [31:0] d; } exp_t;
    exp_t sbq[$];
    exp_t me;
    int   vectors = 0, miscompares = 0;
    bit   to_mode = 1'b0;
    logic p_clr = 1'b0, p_done = 1'b0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endfunction

    // Monitor: compare every response strobe with the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                else begin
                    me = sbq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(1 << me.ch));
                    chk("rsp_data", 64'(rsp_data), 64'(me.d));
                    chk("grant_id", 64'(grant_id), 64'(me.ch));
                    if (!to_mode) begin
                        chk("done_then_rsp", 64'(p_done), 64'd1);
                        chk("err_low", 64'(err), 64'd0);
                    end
                end
            end
            if (mac_start) chk("clr_then_start", 64'(p_clr), 64'd1);
            p_clr  = mac_clr;
            p_done = mac_done;
        end
    end

    // Requester job tables and the round-robin reference model.
    int          jn[N], ji[N];
    logic [DW-1:0] ja[N][8], jb[N][8];
    int          m_last = N - 1;

    task automatic clear_jobs();
        for (int c = 0; c < N; c++) begin jn[c] = 0; ji[c] = 0; end
    endtask

    task automatic predict();
        int rem[N]; int k[N]; int tot = 0;
        for (int c = 0; c < N; c++) begin rem[c] = jn[c]; k[c] = 0; tot += jn[c]; end
        repeat (tot) begin
            for (int off = 1; off <= N; off++) begin
                int c;
                c = (m_last + off) % N;
                if (rem[c] > 0) begin
                    sbq.push_back('{c, 32'(ja[c][k[c]]) * 32'(jb[c][k[c]])});
                    k[c]++; rem[c]--; m_last = c;
                    break;
                end
            end
        end
    endtask

    task automatic drive_ops();
        for (int c = 0; c < N; c++) begin
            req[c] = (ji[c] < jn[c]);
            if (ji[c] < jn[c]) begin
                req_a[c*DW +: DW] = ja[c][ji[c]];
                req_b[c*DW +: DW] = jb[c][ji[c]];
            end
        end
    endtask

    task automatic run_batch(input int budget);
        int t = 0;
        for (int c = 0; c < N; c++) ji[c] = 0;
        predict();
        drive_ops();
        while (req != '0 && t < budget) begin
            @(posedge clk); #1; t++;
            for (int c = 0; c < N; c++) if (rsp_valid[c] && req[c]) ji[c]++;
            drive_ops();
        end
        if (t >= budget) chk("batch_budget", 64'(t), 64'(budget - 1));
        repeat (3) @(posedge clk);
        #1 chk("batch_drained", 64'(sbq.size()), 64'd0);
    endtask

    function automatic logic [DW-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic chk_zero(string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_grant"}, 64'(grant_id), 0);
        chk({tag, "_clr"}, 64'(mac_clr), 0);
        chk({tag, "_start"}, 64'(mac_start), 0);
        chk({tag, "_mac_a"}, 64'(mac_a), 0);
        chk({tag, "_mac_b"}, 64'(mac_b), 0);
        chk({tag, "_err"}, 64'(err), 0);
    endtask

    initial begin
        int t;
        rst = 1'b0; req = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) chk_zero("reset");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Single request: timing of clr/start and 7*9 result.
        clear_jobs(); jn[0] = 1; ja[0][0] = 7; jb[0][0] = 9; m_lat = 16;
        predict(); drive_ops();
        @(posedge clk); #1;
        chk("c1_clr", 64'(mac_clr), 1); chk("c1_start", 64'(mac_start), 0);
        chk("c1_busy", 64'(busy), 1);
        @(posedge clk); #1;
        chk("c2_start", 64'(mac_start), 1); chk("c2_clr", 64'(mac_clr), 0);
        chk("c2_mac_a", 64'(mac_a), 7); chk("c2_mac_b", 64'(mac_b), 9);
        t = 0;
        while (!rsp_valid[0] && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) chk("single_budget", 64'(t), 64'd99);
        ji[0] = 1; drive_ops();
        repeat (2) @(posedge clk);
        #1 chk("single_drained", 64'(sbq.size()), 0);

        // Fairness: ch1 keeps requesting, ch2 once -> 1,2,1,1.
        clear_jobs(); m_lat = 3;
        jn[1] = 3; for (int k = 0; k < 3; k++) begin ja[1][k] = DW'(k + 1); jb[1][k] = DW'(k + 2); end
        jn[2] = 1; ja[2][0] = 5; jb[2][0] = 5;
        run_batch(500);

        // Boundary operands.
        clear_jobs(); jn[3] = 2;
        ja[3][0] = 16'hFFFF; jb[3][0] = 16'hFFFF; ja[3][1] = 0; jb[3][1] = 16'h1234;
        run_batch(500);

        // All four at once -> 0,1,2,3.
        clear_jobs();
        for (int c = 0; c < N; c++) begin jn[c] = 1; ja[c][0] = DW'(2*c + 2); jb[c][0] = DW'(2*c + 3); end
        run_batch(500);

        // Request dropped after grant: response still arrives.
        clear_jobs(); jn[3] = 1; ja[3][0] = 11; jb[3][0] = 13;
        predict(); drive_ops();
        repeat (3) @(posedge clk);
        #1 req = '0;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
        chk("drop_drained", 64'(sbq.size()), 0);

        // Reset mid-WAIT: no response, outputs cleared, ch0 first afterwards.
        repeat (2) @(posedge clk); #1;
        m_hang = 1'b1; req[2] = 1'b1; req_a[2*DW +: DW] = 5; req_b[2*DW +: DW] = 6;
        repeat (6) @(posedge clk); #1;
        chk("rw_busy", 64'(busy), 1);
        rst = 1'b0;
        @(negedge clk) chk_zero("rw");
        repeat (2) @(posedge clk); #1;
        req = '0; rst = 1'b1; m_hang = 1'b0; m_last = N - 1;
        @(posedge clk); #1;
        clear_jobs(); jn[0] = 1; ja[0][0] = 3; jb[0][0] = 3; jn[3] = 1; ja[3][0] = 4; jb[3][0] = 4;
        run_batch(500);

        // Randomized batches.
        repeat (20) begin
            clear_jobs();
            for (int c = 0; c < N; c++) begin
                jn[c] = $urandom_range(0, 3);
                for (int k = 0; k < 3; k++) begin ja[c][k] = rnd_op(); jb[c][k] = rnd_op(); end
            end
            m_lat = $urandom_range(1, 8);
            run_batch(3000);
        end

`ifdef MAC_TIMEOUT_EN
        // MAC never completes: response with zero data TO+1 cycles after WAIT entry.
        to_mode = 1'b1; m_hang = 1'b1;
        clear_jobs(); jn[1] = 1; ja[1][0] = 9; jb[1][0] = 9;
        for (int c = 0; c < N; c++) ji[c] = 0;
        sbq.push_back('{1, 32'd0});
        m_last = 1;
        drive_ops();
        t = 0;
        while (!mac_start && t < 20) begin @(posedge clk); #1; t++; end
        t = 0;
        while (!rsp_valid[1] && t < 4*TO) begin @(posedge clk); #1; t++; end
        chk("to_latency", 64'(t - 1), 64'(TO + 1));
        chk("to_err", 64'(err), 1);
        ji[1] = 1; drive_ops();
        m_hang = 1'b0;
        clear_jobs(); jn[2] = 1; ja[2][0] = 2; jb[2][0] = 2;
        run_batch(500);
        chk("to_err_sticky", 64'(err), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
